// File: rtl/seq_mult_if.sv
// Handshake and result bundle for the sequential shift-add multiplier.
interface seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier, one partial product per BUSY cycle.
// Define SEQ_MULT_EARLY_TERM_EN to finish immediately when either operand is zero.
module seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_mult_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mcand, mcand_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [WIDTH-1:0]   mq, mq_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [2*WIDTH-1:0] product_nx;
  logic [WIDTH:0]     sum;

  // Next-state and datapath: accept in IDLE/DONE, one add-shift step per BUSY cycle
  always_comb begin
    state_nx   = state;
    mcand_nx   = mcand;
    acc_nx     = acc;
    mq_nx      = mq;
    cnt_nx     = cnt;
    product_nx = bus.product;
    sum        = '0;
    case (state)
      S_BUSY: begin
        sum    = mq[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
        acc_nx = sum[WIDTH:1];
        mq_nx  = {sum[0], mq[WIDTH-1:1]};
        cnt_nx = cnt - CW'(1);
        if (cnt_nx == '0) begin
          state_nx   = S_DONE;
          product_nx = {acc_nx, mq_nx};
        end
      end
      default: begin
        state_nx = S_IDLE;
        if (bus.start) begin
          mcand_nx = bus.a;
          acc_nx   = '0;
          mq_nx    = bus.b;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (bus.a == '0 || bus.b == '0) begin
            cnt_nx     = '0;
            state_nx   = S_DONE;
            product_nx = '0;
          end else
`endif
          begin
            cnt_nx   = CW'(WIDTH);
            state_nx = S_BUSY;
          end
        end
      end
    endcase
  end

  // State, datapath and registered status decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mcand       <= '0;
      acc         <= '0;
      mq          <= '0;
      cnt         <= '0;
      bus.product <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_nx;
      mcand       <= mcand_nx;
      acc         <= acc_nx;
      mq          <= mq_nx;
      cnt         <= cnt_nx;
      bus.product <= product_nx;
      bus.busy    <= (state_nx == S_BUSY);
      bus.done    <= (state_nx == S_DONE);
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: vector table, random operands against an
// arithmetic model, and hand sequences for restart, ignored start and reset abort.
module tb_seq_mult;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus8 ();
  seq_mult_if #(.WIDTH(4)) bus4 ();

  seq_mult #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus8));
  seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a     = W'($urandom);
    bus8.b     = W'($urandom);
  endtask

  // Watch from cycle cyc0 until done, bounded; report done cycle, product, busy count
  task automatic wait_done(input int cyc0, output int dcyc, output logic [2*W-1:0] prod,
                           output int nbusy, output bit stable);
    logic [2*W-1:0] p0;
    int cyc;
    cyc    = cyc0;
    dcyc   = -1;
    nbusy  = 0;
    stable = 1'b1;
    prod   = '0;
    p0     = bus8.product;
    repeat (40) begin
      if (bus8.done === 1'b1) begin
        dcyc = cyc;
        prod = bus8.product;
        break;
      end
      if (bus8.busy === 1'b1) nbusy++;
      if (bus8.product !== p0) stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p);
    int dcyc, nbusy;
    logic [2*W-1:0] prod;
    bit stable;
    kick(a, b);
    wait_done(1, dcyc, prod, nbusy, stable);
    check({name, "_product"}, 64'(prod), 64'(p));
    check({name, "_done_cycle"}, 64'(dcyc), 64'(exp_lat(a, b)));
    check({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat(a, b) - 1));
    check({name, "_product_hold"}, 64'(stable), 64'd1);
    @(posedge clk); #1;
    check({name, "_done_single"}, 64'(bus8.done), 64'd0);
    check({name, "_idle_after"}, 64'(bus8.busy), 64'd0);
  endtask

  initial begin
    int dcyc, nbusy, cyc, ndone;
    logic [2*W-1:0] prod;
    logic [W-1:0] ra, rb;
    bit stable;

    tbl[0] = '{8'd13,  8'd11,  16'd143};
    tbl[1] = '{8'd255, 8'd255, 16'd65025};
    tbl[2] = '{8'd0,   8'd200, 16'd0};
    tbl[3] = '{8'd1,   8'd1,   16'd1};
    tbl[4] = '{8'd200, 8'd0,   16'd0};
    tbl[5] = '{8'd128, 8'd2,   16'd256};
    tbl[6] = '{8'd1,   8'd255, 16'd255};
    tbl[7] = '{8'd170, 8'd85,  16'd14450};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_product", 64'(bus8.product), 64'd0);
    check("rst4_product", 64'(bus4.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 3) ra = '1;
      if (i % 9 == 5) rb = '0;
      run_vec($sformatf("rnd%0d", i), ra, rb, (2*W)'(32'(ra) * 32'(rb)));
    end

    // Start during BUSY is ignored
    kick(8'd7, 8'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done(5, dcyc, prod, nbusy, stable);
    check("ign_product", 64'(prod), 64'd42);
    check("ign_done_cycle", 64'(dcyc), 64'd9);
    @(posedge clk); #1;
    check("ign_idle_after", 64'(bus8.busy), 64'd0);

    // Start held high: back-to-back restart from DONE without an IDLE gap
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd5;
    @(posedge clk); #1;
    bus8.a = 8'd4; bus8.b = 8'd4;
    wait_done(1, dcyc, prod, nbusy, stable);
    check("b2b_first_product", 64'(prod), 64'd15);
    check("b2b_first_done_cycle", 64'(dcyc), 64'd9);
    @(posedge clk); #1;
    check("b2b_rebusy", 64'(bus8.busy), 64'd1);
    bus8.start = 1'b0;
    wait_done(10, dcyc, prod, nbusy, stable);
    check("b2b_second_product", 64'(prod), 64'd16);
    check("b2b_second_done_cycle", 64'(dcyc), 64'd18);

    // Reset mid-BUSY aborts with no done pulse
    kick(8'd50, 8'd3);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(bus8.busy), 64'd0);
    check("abort_done", 64'(bus8.done), 64'd0);
    check("abort_product", 64'(bus8.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    // Reset while in DONE, then start on the first edge after reset release
    kick(8'd2, 8'd3);
    wait_done(1, dcyc, prod, nbusy, stable);
    check("rdone_product_pre", 64'(prod), 64'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rdone_product", 64'(bus8.product), 64'd0);
    check("rdone_done", 64'(bus8.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus8.start = 1'b1; bus8.a = 8'd12; bus8.b = 8'd12;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done(1, dcyc, prod, nbusy, stable);
    check("first_edge_product", 64'(prod), 64'd144);
    check("first_edge_done_cycle", 64'(dcyc), 64'd9);

    // Narrow instance: WIDTH=4
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.a = (k == 0) ? 4'd15 : 4'd9;
      bus4.b = (k == 0) ? 4'd15 : 4'd7;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      bus4.a = 4'd0; bus4.b = 4'd0;
      cyc  = 1;
      dcyc = -1;
      repeat (20) begin
        if (bus4.done === 1'b1) begin dcyc = cyc; break; end
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("w4_%0d_product", k), 64'(bus4.product), (k == 0) ? 64'd225 : 64'd63);
      check($sformatf("w4_%0d_done_cycle", k), 64'(dcyc), 64'd5);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  unsigned multiplicand; sampled only when start is accepted.
REQ-006 Port: b  input  WIDTH  unsigned multiplier; sampled only when start is accepted.
REQ-007 Port: busy  output  1  high while a multiply is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a valid new product.
REQ-009 Port: product  output  2*WIDTH  result register; holds its value between completions.

Function
REQ-010 The block SHALL implement a shift-add multiplier with a three-state FSM: IDLE, BUSY and DONE.
REQ-011 A start SHALL be accepted in IDLE or DONE; a start in BUSY SHALL be ignored, with no effect on the result or timing.
REQ-012 On acceptance the block SHALL latch a into a multiplicand register and b into the low half of a combined {acc, mq} register, clear acc, load the iteration counter with WIDTH, and enter BUSY.
REQ-013 Each BUSY cycle, when mq[0]=1 the block SHALL form the (WIDTH+1)-bit sum {carry, acc+multiplicand}; otherwise it SHALL use {0, acc}.
REQ-014 Each BUSY cycle the block SHALL then shift {carry, acc, mq} right by one bit and decrement the counter.
REQ-015 When the counter reaches 0 the block SHALL enter DONE and load product with {acc, mq}.
REQ-016 DONE SHALL last exactly one cycle; the next state SHALL be BUSY if start=1, otherwise IDLE.
REQ-017 busy SHALL be 1 exactly in BUSY, and done SHALL be 1 exactly in DONE (both are registered state decodes).
REQ-018 Latency: with start accepted at edge 0, busy SHALL be high for cycles 1..WIDTH and done SHALL be high in cycle WIDTH+1.
REQ-019 product SHALL change only on the edge entering DONE or on reset; intermediate values SHALL never appear on product.
REQ-020 Arithmetic SHALL be exact modulo 2^(2*WIDTH); no overflow is possible, and the maximum result is (2^WIDTH-1)^2.
REQ-021 Changes on a or b after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-022 While rst=1 at a clock edge, the state SHALL become IDLE, and busy, done, product, acc, mq, the multiplicand register and the counter SHALL all become 0.
REQ-023 Reset SHALL take priority over start and SHALL abort any operation in progress, mid-BUSY or in DONE, with no done pulse.
REQ-024 The first start SHALL be acceptable on the first edge after rst deasserts.

Configuration
REQ-025 Macro SEQ_MULT_EARLY_TERM_EN SHALL control zero-operand early termination.
REQ-026 With SEQ_MULT_EARLY_TERM_EN defined, an accepted start with a=0 or b=0 SHALL skip BUSY, go straight to DONE, and load product with 0 (done in cycle 1).
REQ-027 Without SEQ_MULT_EARLY_TERM_EN, every accepted start SHALL take the full WIDTH BUSY cycles, irrespective of operand values.

Verification
REQ-028 WIDTH=8: a=13, b=11, start pulsed at edge 0 -> busy high in cycles 1-8, done in cycle 9, product=143.
REQ-029 WIDTH=8: a=255, b=255 -> product=65025 (0xFE01) with done in cycle 9; WIDTH=4: a=15, b=15 -> product=225 with done in cycle 5.
REQ-030 WIDTH=8: start with a=7, b=6, then start with a=9, b=9 in cycle 4, during BUSY -> second start ignored; product=42 in cycle 9.
REQ-031 WIDTH=8: start held high with a=3, b=5, then a=4, b=4 -> product=15 in cycle 9, BUSY re-entered with no IDLE gap, product=16 in cycle 18.
REQ-032 WIDTH=8: rst=1 in cycle 5 of a multiply -> busy=0, done=0, product=0 next cycle; no done pulse follows.
REQ-033 WIDTH=8: a=0, b=200 -> product=0 with done in cycle 1 when SEQ_MULT_EARLY_TERM_EN is defined, and done in cycle 9 without it.
